// File: rtl/ofifo_pkg.sv
// Shared sizing for the south-edge output FIFO.
// Defaults track the MAC array's own parameters.
package ofifo_pkg;
    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int DEPTH   = 16;
    localparam int PTR_W   = $clog2(DEPTH);
endpackage

// File: rtl/ofifo_col_fifo.sv
// Single-column psum FIFO; read data is combinational mem[rptr].
// rd is an already-gated pop, so it is never high while empty.
module col_fifo
    import ofifo_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic               rd,
    input  logic [psum_bw-1:0] in,
    output logic [psum_bw-1:0] out,
    output logic               empty,
    output logic               full,
    output logic               drop
);
    localparam int AW = $clog2(depth);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(depth);

    logic [psum_bw-1:0] mem [depth];
    logic [AW-1:0]      wptr;
    logic [AW-1:0]      rptr;
    logic [AW:0]        count;
    logic               acc;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    // A pop in the same cycle frees the slot the write lands in.
    assign acc   = wr && (!full || rd);
    assign drop  = wr && full && !rd;
    assign out   = mem[rptr];

    always_ff @(posedge clk) begin
        if (acc) begin
            mem[wptr] <= in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (acc) begin
                wptr <= wptr + 1'b1;
            end
            if (rd) begin
                rptr <= rptr + 1'b1;
            end
            case ({acc, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/ofifo.sv
// Output FIFO below the MAC array: one FIFO per column, rows released
// only when every column holds data.
module ofifo
    import ofifo_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col-1:0]         wr,
    input  logic [psum_bw*col-1:0] in,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_overflow
);
    logic [col-1:0]         empty;
    logic [col-1:0]         full;
    logic [col-1:0]         drop;
    logic [psum_bw*col-1:0] row;
    logic                   pop;

    assign o_valid = ~|empty;
    assign o_full  = |full;
    assign o_ready = ~|full;
    assign pop     = rd && o_valid;

    for (genvar i = 0; i < col; i++) begin : g_col
        col_fifo #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[i]),
            .rd    (pop),
            .in    (in[psum_bw*i +: psum_bw]),
            .out   (row[psum_bw*i +: psum_bw]),
            .empty (empty[i]),
            .full  (full[i]),
            .drop  (drop[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out <= '0;
        end else if (pop) begin
            out <= row;
        end
    end

    // Sticky until reset so software can find a lost psum after the fact.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_overflow <= 1'b0;
        end else if (|drop) begin
            o_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ofifo.sv
// Directed bench for ofifo with a queue-based reference model
// checked on every falling edge.
module tb_ofifo;
    localparam int C = 8;
    localparam int W = 16;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [C-1:0] wr;
    logic [W*C-1:0] din;
    logic         rd;
    logic [W*C-1:0] out;
    logic         o_valid;
    logic         o_full;
    logic         o_ready;
    logic         o_overflow;

    int checks = 0;
    int failures = 0;

    logic [W-1:0]   q [C][$];
    logic [W*C-1:0] m_out;
    logic           m_ovf;
    logic           started = 1'b0;

    ofifo dut (
        .clk        (clk),
        .reset      (reset),
        .wr         (wr),
        .in         (din),
        .rd         (rd),
        .out        (out),
        .o_valid    (o_valid),
        .o_full     (o_full),
        .o_ready    (o_ready),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W*C-1:0] act,
                         input logic [W*C-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W*C-1:0] rowv(input logic [W-1:0] v);
        return {C{v}};
    endfunction

    function automatic logic m_valid();
        for (int i = 0; i < C; i++)
            if (q[i].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_full();
        for (int i = 0; i < C; i++)
            if (q[i].size() == D) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: pop happens before writes, so a full column with
    // a concurrent pop has room for the incoming word.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < C; i++) q[i].delete();
            m_out = '0;
            m_ovf = 1'b0;
            started = 1'b1;
        end else begin
            logic pop;
            pop = rd && m_valid();
            if (pop) begin
                for (int i = 0; i < C; i++)
                    m_out[W*i +: W] = q[i].pop_front();
            end
            for (int i = 0; i < C; i++) begin
                if (wr[i]) begin
                    if (q[i].size() < D) q[i].push_back(din[W*i +: W]);
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("model_out", out, m_out);
            check("model_valid", {127'd0, o_valid}, {127'd0, m_valid()});
            check("model_full", {127'd0, o_full}, {127'd0, m_full()});
            check("model_ready", {127'd0, o_ready}, {127'd0, !m_full()});
            check("model_ovf", {127'd0, o_overflow}, {127'd0, m_ovf});
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        rd    = 1'b1;
        wr    = '0;
        din   = '0;
        repeat (2) @(posedge clk);
        cyc();
        check("rst_out", out, '0);
        check("rst_valid", {127'd0, o_valid}, 128'd0);
        check("rst_ready", {127'd0, o_ready}, 128'd1);
        check("rst_ovf", {127'd0, o_overflow}, 128'd0);
        reset = 1'b0;
        rd    = 1'b0;

        // skewed fill
        for (int i = 0; i < C; i++) begin
            wr  = C'(1) << i;
            din = '0;
            din[W*i +: W] = 16'h0100 + W'(i);
            cyc();
            check($sformatf("skew_valid_%0d", i), {127'd0, o_valid},
                  (i == C-1) ? 128'd1 : 128'd0);
        end
        wr = '0;
        rd = 1'b1;
        cyc();
        check("skew_row", out,
              128'h0107_0106_0105_0104_0103_0102_0101_0100);
        check("skew_valid_after", {127'd0, o_valid}, 128'd0);

        // streaming with wrap
        for (int r = 0; r < 40; r++) begin
            wr  = '1;
            din = rowv(W'(r));
            cyc();
            if (r > 0) check("stream_row", out, rowv(W'(r - 1)));
        end
        wr = '0;
        repeat (2) cyc();
        check("stream_last", out, rowv(16'd39));
        rd = 1'b0;

        // full and overflow on column 3
        for (int k = 0; k < D; k++) begin
            wr  = 8'h08;
            din = '0;
            din[W*3 +: W] = W'(k);
            cyc();
        end
        check("col3_full", {127'd0, o_full}, 128'd1);
        check("col3_ready", {127'd0, o_ready}, 128'd0);
        cyc();
        check("col3_ovf", {127'd0, o_overflow}, 128'd1);
        wr = '0;
        repeat (3) cyc();
        check("ovf_sticky", {127'd0, o_overflow}, 128'd1);
        check("col3_still_full", {127'd0, o_full}, 128'd1);

        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("ovf_cleared", {127'd0, o_overflow}, 128'd0);

        // write and pop together on full columns
        for (int r = 0; r < D; r++) begin
            wr  = '1;
            din = rowv(16'h1000 + W'(r));
            cyc();
        end
        check("all_full", {127'd0, o_full}, 128'd1);
        rd  = 1'b1;
        din = rowv(16'hAAAA);
        cyc();
        check("wp_row0", out, rowv(16'h1000));
        check("wp_full", {127'd0, o_full}, 128'd1);
        check("wp_ovf", {127'd0, o_overflow}, 128'd0);
        wr = '0;
        repeat (D) cyc();
        check("wp_row17", out, rowv(16'hAAAA));
        check("wp_drained", {127'd0, o_valid}, 128'd0);
        rd = 1'b0;

        // reset with data buffered
        for (int r = 0; r < 5; r++) begin
            wr  = '1;
            din = rowv(16'h2000 + W'(r));
            cyc();
        end
        wr    = '0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("mid_valid", {127'd0, o_valid}, 128'd0);
        check("mid_out", out, '0);
        wr  = '1;
        din = rowv(16'h3333);
        cyc();
        wr = '0;
        rd = 1'b1;
        cyc();
        check("mid_new_row", out, rowv(16'h3333));
        check("mid_empty", {127'd0, o_valid}, 128'd0);
        rd = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
